plat_collision_scanner: RTL and testbench

//  Sequential landing-check engine for the current block's platform table. On request it latches the

---
 rtl/plat_collision_scanner_if.sv | 31 +++
 rtl/plat_collision_scanner.sv | 142 ++++++++++++++
 tb/tb_plat_collision_scanner.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plat_collision_scanner_if.sv
// Request/table/result bundle between the block generator, physics controller and the landing scanner.
interface plat_collision_scanner_if #(
  parameter int PLATFORM_NUM    = 7,
  parameter int PHY_WIDTH       = 16,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int IDX_WIDTH       = 3
);
  logic                                    req;
  logic [PHY_WIDTH-1:0]                    char_x;
  logic [PHY_WIDTH-1:0]                    char_y;
  logic [PHY_WIDTH-1:0]                    fall_dy;
  logic [PLATFORM_NUM*PHY_WIDTH-1:0]       plat_relative_x;
  logic [PLATFORM_NUM*PHY_WIDTH-1:0]       plat_relative_y;
  logic [PLATFORM_NUM*BLOCK_LEN_WIDTH-1:0] plat_len;
  logic                                    block_switch;
  logic                                    busy;
  logic                                    done;
  logic                                    hit;
  logic [IDX_WIDTH-1:0]                    hit_idx;
  logic [PHY_WIDTH-1:0]                    hit_y;

  modport master (
    output req, char_x, char_y, fall_dy, plat_relative_x, plat_relative_y, plat_len, block_switch,
    input  busy, done, hit, hit_idx, hit_y
  );

  modport slave (
    input  req, char_x, char_y, fall_dy, plat_relative_x, plat_relative_y, plat_len, block_switch,
    output busy, done, hit, hit_idx, hit_y
  );
endinterface

// File: rtl/plat_collision_scanner.sv
// Landing-check engine: snapshots the platform table on req, scans one entry per cycle and reports
// the highest platform top inside [feet - fall_dy, feet] that overlaps the hitbox, N cycles after accept.
module plat_collision_scanner #(
  parameter int PLATFORM_NUM    = 7,
  parameter int PHY_WIDTH       = 16,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int TILE_W          = 8,
  parameter int CHAR_W          = 16,
  parameter int IDX_WIDTH       = 3
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  plat_collision_scanner_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(PLATFORM_NUM - 1);
  localparam logic [PHY_WIDTH:0]   TILE_W_X  = (PHY_WIDTH+1)'(TILE_W);
  localparam logic [PHY_WIDTH:0]   CHAR_W_X  = (PHY_WIDTH+1)'(CHAR_W);

  logic [0:0]                                    state;
  logic [IDX_WIDTH-1:0]                          idx;
  logic [PHY_WIDTH-1:0]                          snap_x;
  logic [PHY_WIDTH-1:0]                          snap_y;
  logic [PHY_WIDTH-1:0]                          snap_dy;
  logic [PLATFORM_NUM-1:0][PHY_WIDTH-1:0]        tab_x;
  logic [PLATFORM_NUM-1:0][PHY_WIDTH-1:0]        tab_y;
  logic [PLATFORM_NUM-1:0][BLOCK_LEN_WIDTH-1:0]  tab_len;

  logic                 best_vld;
  logic [IDX_WIDTH-1:0] best_idx;
  logic [PHY_WIDTH-1:0] best_y;

  logic                 done_q;
  logic                 hit_q;
  logic [IDX_WIDTH-1:0] hit_idx_q;
  logic [PHY_WIDTH-1:0] hit_y_q;

  logic [PHY_WIDTH-1:0]       cur_x;
  logic [PHY_WIDTH-1:0]       cur_y;
  logic [BLOCK_LEN_WIDTH-1:0] cur_len;
  logic [PHY_WIDTH:0]         cur_w;
  logic [PHY_WIDTH-1:0]       lo;
  logic                       x_ov;
  logic                       y_ok;
  logic                       contact;
  logic                       take;
  logic                       nxt_vld;
  logic [IDX_WIDTH-1:0]       nxt_idx;
  logic [PHY_WIDTH-1:0]       nxt_y;

  assign cur_x   = tab_x[idx];
  assign cur_y   = tab_y[idx];
  assign cur_len = tab_len[idx];
  assign cur_w   = (PHY_WIDTH+1)'(cur_len) * TILE_W_X;

  // Lower edge of the swept feet interval saturates at 0 instead of wrapping.
  assign lo = (snap_y >= snap_dy) ? (snap_y - snap_dy) : '0;

  assign x_ov    = (({1'b0, snap_x} + CHAR_W_X) > {1'b0, cur_x}) &&
                   ({1'b0, snap_x} < ({1'b0, cur_x} + cur_w));
  assign y_ok    = (cur_y >= lo) && (cur_y <= snap_y);
  assign contact = (cur_len != '0) && x_ov && y_ok;

  // Strictly-greater update keeps the lower index on equal heights.
  assign take    = contact && (!best_vld || (cur_y > best_y));
  assign nxt_vld = best_vld | take;
  assign nxt_idx = take ? idx   : best_idx;
  assign nxt_y   = take ? cur_y : best_y;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      snap_x    <= '0;
      snap_y    <= '0;
      snap_dy   <= '0;
      tab_x     <= '0;
      tab_y     <= '0;
      tab_len   <= '0;
      best_vld  <= 1'b0;
      best_idx  <= '0;
      best_y    <= '0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      hit_y_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            snap_x   <= bus.char_x;
            snap_y   <= bus.char_y;
            snap_dy  <= bus.fall_dy;
            tab_x    <= bus.plat_relative_x;
            tab_y    <= bus.plat_relative_y;
            tab_len  <= bus.plat_len;
            idx      <= '0;
            best_vld <= 1'b0;
            best_idx <= '0;
            best_y   <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (bus.block_switch) begin
            // New block: restart over the fresh table, character latches stay.
            tab_x    <= bus.plat_relative_x;
            tab_y    <= bus.plat_relative_y;
            tab_len  <= bus.plat_len;
            idx      <= '0;
            best_vld <= 1'b0;
            best_idx <= '0;
            best_y   <= '0;
          end else if (idx == LAST_IDX) begin
            hit_q     <= nxt_vld;
            hit_idx_q <= nxt_idx;
            hit_y_q   <= nxt_y;
            done_q    <= 1'b1;
            state     <= IDLE;
          end else begin
            best_vld <= nxt_vld;
            best_idx <= nxt_idx;
            best_y   <= nxt_y;
            idx      <= idx + IDX_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == SCAN);
  assign bus.done    = done_q;
  assign bus.hit     = hit_q;
  assign bus.hit_idx = hit_idx_q;
  assign bus.hit_y   = hit_y_q;

endmodule

// File: tb/tb_plat_collision_scanner.sv
// Bench for plat_collision_scanner: directed vector table, hand-written multi-cycle sequences and
// randomized scans checked against a brute-force landing model.
module tb_plat_collision_scanner;
  localparam int N  = 7;
  localparam int PW = 16;
  localparam int LW = 4;
  localparam int IW = 3;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  plat_collision_scanner_if #(.PLATFORM_NUM(N), .PHY_WIDTH(PW), .BLOCK_LEN_WIDTH(LW), .IDX_WIDTH(IW)) bus();

  plat_collision_scanner #(
    .PLATFORM_NUM(N), .PHY_WIDTH(PW), .BLOCK_LEN_WIDTH(LW),
    .TILE_W(8), .CHAR_W(16), .IDX_WIDTH(IW)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] tx[N];
  logic [15:0] ty[N];
  logic [3:0]  tl[N];

  typedef struct {
    int    tab;
    int    x;
    int    y;
    int    dy;
    int    eh;
    int    ei;
    int    ey;
    string name;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_table();
    for (int i = 0; i < N; i++) begin
      bus.plat_relative_x[i*PW +: PW] = tx[i];
      bus.plat_relative_y[i*PW +: PW] = ty[i];
      bus.plat_len[i*LW +: LW]        = tl[i];
    end
  endtask

  task automatic set_entry(input int i, input int x, input int y, input int l);
    tx[i] = 16'(x);
    ty[i] = 16'(y);
    tl[i] = 4'(l);
  endtask

  task automatic load_table(input int sel);
    for (int i = 0; i < N; i++) set_entry(i, 0, 0, 0);
    case (sel)
      0, 6: begin
        set_entry(0, 280, 35, 10);  set_entry(1, 100, 100, 8); set_entry(2, 370, 150, 10);
        set_entry(3, 30, 250, 8);   set_entry(4, 250, 280, 8); set_entry(5, 120, 380, 8);
        set_entry(6, 400, 380, 8);
        if (sel == 6) set_entry(2, 280, 38, 10);
      end
      1: begin set_entry(1, 100, 100, 8); set_entry(3, 100, 90, 8);  end
      2: begin set_entry(1, 100, 100, 8); set_entry(3, 100, 100, 8); end
      3: set_entry(0, 0, 0, 4);
      4: set_entry(0, 0, 0, 0);
      5: set_entry(0, 100, 50, 2);
      default: ;
    endcase
    drive_table();
  endtask

  // Brute-force landing rule: highest top inside the swept interval with hitbox overlap, lowest index on ties.
  task automatic model(input int x, input int y, input int dy, output int h, output int hi, output int hy);
    int lo;
    int px;
    int py;
    int w;
    h = 0; hi = 0; hy = 0;
    lo = (y >= dy) ? y - dy : 0;
    for (int k = 0; k < N; k++) begin
      px = int'(tx[k]);
      py = int'(ty[k]);
      w  = int'(tl[k]) * 8;
      if (tl[k] != 0 && x + 16 > px && x < px + w && py >= lo && py <= y && (h == 0 || py > hy)) begin
        h = 1; hi = k; hy = py;
      end
    end
  endtask

  task automatic set_char(input int x, input int y, input int dy);
    bus.char_x  = 16'(x);
    bus.char_y  = 16'(y);
    bus.fall_dy = 16'(dy);
  endtask

  // Starts at a negedge with busy low, returns at the negedge where done is seen.
  task automatic run_scan(input int x, input int y, input int dy,
                          input int eh, input int ei, input int ey, input string name);
    int lat;
    set_char(x, y, dy);
    bus.req = 1'b1;
    @(negedge sys_clk);
    bus.req = 1'b0;
    check({name, " busy"}, int'(bus.busy), 1);
    lat = 0;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      @(negedge sys_clk);
      if (bus.done) lat = c;
    end
    check({name, " latency"}, lat, 7);
    if (lat != 0) begin
      check({name, " hit"}, int'(bus.hit), eh);
      if (eh != 0) begin
        check({name, " hit_idx"}, int'(bus.hit_idx), ei);
        check({name, " hit_y"}, int'(bus.hit_y), ey);
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " busy"},    int'(bus.busy), 0);
    check({name, " done"},    int'(bus.done), 0);
    check({name, " hit"},     int'(bus.hit), 0);
    check({name, " hit_idx"}, int'(bus.hit_idx), 0);
    check({name, " hit_y"},   int'(bus.hit_y), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int lat;
    int h;
    int hi;
    int hy;
    int big;
    int p;
    int x;
    int y;
    int dy;

    vecs[0]  = '{0, 290,  40, 10, 1, 0,  35, "t2_low_plat"};
    vecs[1]  = '{0,   0,  40, 10, 0, 0,   0, "t3_no_overlap"};
    vecs[2]  = '{1, 110, 105, 20, 1, 1, 100, "t4_highest"};
    vecs[3]  = '{2, 110, 105, 20, 1, 1, 100, "t4_tie_low_idx"};
    vecs[4]  = '{3,  10,   5, 10, 1, 0,   0, "t6_clamp"};
    vecs[5]  = '{4,  10,   5, 10, 0, 0,   0, "t6_len_zero"};
    vecs[6]  = '{5,  84,  50,  0, 0, 0,   0, "x_left_touch"};
    vecs[7]  = '{5,  85,  50,  0, 1, 0,  50, "x_left_overlap"};
    vecs[8]  = '{5, 115,  50,  0, 1, 0,  50, "x_right_overlap"};
    vecs[9]  = '{5, 116,  50,  0, 0, 0,   0, "x_right_touch"};
    vecs[10] = '{5, 100,  49,  0, 0, 0,   0, "y_above_feet"};
    vecs[11] = '{5, 100,  60,  9, 0, 0,   0, "y_below_sweep"};
    vecs[12] = '{5, 100,  60, 10, 1, 0,  50, "y_sweep_edge"};

    bus.req = 1'b0;
    bus.block_switch = 1'b0;
    load_table(0);
    set_char(290, 40, 10);

    // Reset with req held high.
    bus.req = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_outputs_zero("t1_reset");
    bus.req = 1'b0;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("t1_post_reset busy", int'(bus.busy), 0);

    // Directed table, issued back-to-back (each req lands in the previous done cycle).
    for (int v = 0; v < 13; v++) begin
      load_table(vecs[v].tab);
      run_scan(vecs[v].x, vecs[v].y, vecs[v].dy, vecs[v].eh, vecs[v].ei, vecs[v].ey, vecs[v].name);
    end
    @(negedge sys_clk);
    check("done_one_cycle", int'(bus.done), 0);

    // Extra req while busy must not produce a second done.
    load_table(0);
    set_char(0, 40, 10);
    bus.req = 1'b1;
    @(negedge sys_clk);
    ndone = 0; lat = 0; h = -1;
    for (int c = 1; c <= 20; c++) begin
      bus.req = (c == 3);
      @(negedge sys_clk);
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin lat = c; h = int'(bus.hit); end
      end
    end
    bus.req = 1'b0;
    check("t3_busy_req done_count", ndone, 1);
    check("t3_busy_req latency", lat, 7);
    check("t3_busy_req hit", h, 0);

    // Randomized scans against the model.
    for (int it = 0; it < 60; it++) begin
      big = ($urandom_range(0, 3) == 0) ? 1 : 0;
      for (int k = 0; k < N; k++) begin
        if (big != 0) begin
          tx[k] = 16'($urandom_range(64900, 65535));
          ty[k] = 16'(65535 - $urandom_range(0, 8) * 50);
        end else begin
          tx[k] = 16'($urandom_range(0, 400));
          ty[k] = 16'($urandom_range(0, 8) * 50);
        end
        tl[k] = 4'($urandom_range(0, 15));
      end
      drive_table();
      p  = int'($urandom_range(0, N - 1));
      x  = int'(tx[p]) + int'($urandom_range(0, 140)) - 40;
      y  = int'(ty[p]) + int'($urandom_range(0, 40));
      dy = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 120));
      if (x < 0) x = 0;
      if (x > 65535) x = 65535;
      if (y > 65535) y = 65535;
      model(x, y, dy, h, hi, hy);
      run_scan(x, y, dy, h, hi, hy, "rand");
    end
    @(negedge sys_clk);

    // block_switch at edge 3 restarts the scan over the new table.
    load_table(0);
    set_char(290, 40, 10);
    bus.req = 1'b1;
    @(negedge sys_clk);
    bus.req = 1'b0;
    ndone = 0; lat = 0; h = -1; hi = -1; hy = -1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        load_table(6);
        bus.block_switch = 1'b1;
      end else begin
        bus.block_switch = 1'b0;
      end
      @(negedge sys_clk);
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          lat = c; h = int'(bus.hit); hi = int'(bus.hit_idx); hy = int'(bus.hit_y);
        end
      end
    end
    bus.block_switch = 1'b0;
    check("t5_switch done_count", ndone, 1);
    check("t5_switch latency", lat, 10);
    check("t5_switch hit", h, 1);
    check("t5_switch hit_idx", hi, 2);
    check("t5_switch hit_y", hy, 38);

    // Reset mid-scan: no done, outputs cleared.
    load_table(0);
    set_char(290, 40, 10);
    bus.req = 1'b1;
    @(negedge sys_clk);
    bus.req = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_mid_reset");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge sys_clk);
      if (bus.done) ndone++;
    end
    check("t6_mid_reset done_count", ndone, 0);
    check("t6_mid_reset busy_after", int'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
